// File: rtl/sync_sample_checker.sv
// ---------------------------------------------------------------------------
// sync_sample_checker
//
// Consumes the output of a two-flop counter synchronizer on the same sample
// clock.  Each sample is compared with the previous one and classified as:
//   hold     : delta == 0
//   advance  : 1 <= delta <= MAX_STEP   (mod 2^DATA_W, so wrap is legal)
//   corrupt  : anything else (metastability / bit-skew glitch)
// A run measures WINDOW compares.  Holds and corrupts are counted with
// saturation, and the first corrupt {prev, cur} pair is captured.
//
// Ports
//   clk           sample clock (same net as the synchronizer capture flops)
//   rst           synchronous reset, active-high
//   start         begins a run from IDLE or DONE; ignored while busy
//   sample        synchronizer output
//   busy          high in LOAD and RUN
//   done          high in DONE, held until start or rst
//   err_pulse     one-cycle pulse per corrupt compare (registered)
//   err_count     corrupt compares this run, saturating
//   hold_count    zero-delta compares this run, saturating
//   first_bad_vld first_bad holds a capture
//   first_bad     {prev, cur} of the first corrupt transition this run
// ---------------------------------------------------------------------------
module sync_sample_checker #(
  parameter int DATA_W   = 4,
  parameter int MAX_STEP = 1,
  parameter int CNT_W    = 16,
  parameter int WINDOW   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     sample,
  output logic                  busy,
  output logic                  done,
  output logic                  err_pulse,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      hold_count,
  output logic                  first_bad_vld,
  output logic [2*DATA_W-1:0]   first_bad
);

  // The sample index only has to reach WINDOW-1, so it is sized from WINDOW
  // rather than CNT_W; this keeps small-counter builds usable with larger
  // windows.
  localparam int                N_W        = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [N_W-1:0]    N_LAST     = N_W'(WINDOW - 1);
  localparam logic [DATA_W:0]   MAX_STEP_W = (DATA_W + 1)'(MAX_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_HOLD    = 2'd0,
    CLS_ADVANCE = 2'd1,
    CLS_CORRUPT = 2'd2
  } cls_t;

  state_t              state_q;
  state_t              state_d;

  logic                clear_run;
  logic                load_en;
  logic                cmp_en;
  logic                last_cmp;

  logic [DATA_W-1:0]   sample_p1;
  logic [N_W-1:0]      n_p1;
  logic [CNT_W-1:0]    err_cnt_p1;
  logic [CNT_W-1:0]    hold_cnt_p1;
  logic                err_pulse_p1;
  logic                fb_vld_p1;
  logic [2*DATA_W-1:0] fb_p1;
  cls_t                cls_p0;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      sat_inc = c;
    end else begin
      sat_inc = c + 1'b1;
    end
  endfunction

  // Forward distance is taken at DATA_W bits so the counter wrap
  // (all-ones -> 0) reads as a single step.
  function automatic cls_t classify(input logic [DATA_W-1:0] cur,
                                    input logic [DATA_W-1:0] prev);
    logic [DATA_W-1:0] delta;
    delta = cur - prev;
    if (delta == '0) begin
      classify = CLS_HOLD;
    end else if ({1'b0, delta} <= MAX_STEP_W) begin
      classify = CLS_ADVANCE;
    end else begin
      classify = CLS_CORRUPT;
    end
  endfunction

  // Stage p0: classify incoming sample against the held previous value
  assign cls_p0   = classify(sample, sample_p1);
  assign last_cmp = (n_p1 == N_LAST);

  always_comb begin
    state_d   = state_q;
    clear_run = 1'b0;
    load_en   = 1'b0;
    cmp_en    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          clear_run = 1'b1;
        end
      end
      LOAD: begin
        load_en = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        cmp_en = 1'b1;
        if (last_cmp) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage p1: register the previous sample, counters, capture and pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_p1    <= '0;
      n_p1         <= '0;
      err_cnt_p1   <= '0;
      hold_cnt_p1  <= '0;
      err_pulse_p1 <= 1'b0;
      fb_vld_p1    <= 1'b0;
      fb_p1        <= '0;
    end else begin
      state_q      <= state_d;
      err_pulse_p1 <= 1'b0;

      if (clear_run) begin
        n_p1        <= '0;
        err_cnt_p1  <= '0;
        hold_cnt_p1 <= '0;
        fb_vld_p1   <= 1'b0;
        fb_p1       <= '0;
      end

      if (load_en) begin
        sample_p1 <= sample;
      end

      if (cmp_en) begin
        sample_p1 <= sample;
        n_p1      <= n_p1 + 1'b1;
        case (cls_p0)
          CLS_HOLD: begin
            hold_cnt_p1 <= sat_inc(hold_cnt_p1);
          end
          CLS_CORRUPT: begin
            err_cnt_p1   <= sat_inc(err_cnt_p1);
            err_pulse_p1 <= 1'b1;
            if (!fb_vld_p1) begin
              fb_vld_p1 <= 1'b1;
              fb_p1     <= {sample_p1, sample};
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign busy          = (state_q == LOAD) || (state_q == RUN);
  assign done          = (state_q == DONE);
  assign err_pulse     = err_pulse_p1;
  assign err_count     = err_cnt_p1;
  assign hold_count    = hold_cnt_p1;
  assign first_bad_vld = fb_vld_p1;
  assign first_bad     = fb_p1;

endmodule

// File: tb/tb_sync_sample_checker.sv
// ---------------------------------------------------------------------------
// tb_sync_sample_checker
//
// Three checker instances share clk/rst/sample:
//   a: WINDOW=8, CNT_W=16   b: WINDOW=4, CNT_W=16   c: WINDOW=6, CNT_W=2
// A selector routes start to one instance and muxes its outputs back.
// Expected results come from a sequence-level model (delta classification
// over an array of samples).
// ---------------------------------------------------------------------------
module tb_sync_sample_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_v = 1'b0;
  logic [3:0] sample = 4'd0;
  int         sel = 0;

  int total = 0;
  int bad   = 0;

  int seq       [0:15];
  int exp_pulse [0:15];

  logic start_a, start_b, start_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic pulse_a, pulse_b, pulse_c;
  logic [15:0] err_a, err_b, hold_a, hold_b;
  logic [1:0]  err_c, hold_c;
  logic fbv_a, fbv_b, fbv_c;
  logic [7:0] fb_a, fb_b, fb_c;

  logic        busy_m, done_m, pulse_m, fbv_m;
  logic [15:0] err_m, hold_m;
  logic [7:0]  fb_m;

  assign start_a = start_v && (sel == 0);
  assign start_b = start_v && (sel == 1);
  assign start_c = start_v && (sel == 2);

  always #5 clk = ~clk;

  sync_sample_checker #(.DATA_W(4), .MAX_STEP(1), .CNT_W(16), .WINDOW(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .sample(sample),
    .busy(busy_a), .done(done_a), .err_pulse(pulse_a),
    .err_count(err_a), .hold_count(hold_a),
    .first_bad_vld(fbv_a), .first_bad(fb_a));

  sync_sample_checker #(.DATA_W(4), .MAX_STEP(1), .CNT_W(16), .WINDOW(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sample(sample),
    .busy(busy_b), .done(done_b), .err_pulse(pulse_b),
    .err_count(err_b), .hold_count(hold_b),
    .first_bad_vld(fbv_b), .first_bad(fb_b));

  sync_sample_checker #(.DATA_W(4), .MAX_STEP(1), .CNT_W(2), .WINDOW(6)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .sample(sample),
    .busy(busy_c), .done(done_c), .err_pulse(pulse_c),
    .err_count(err_c), .hold_count(hold_c),
    .first_bad_vld(fbv_c), .first_bad(fb_c));

  always_comb begin
    busy_m = busy_a; done_m = done_a; pulse_m = pulse_a;
    err_m = err_a; hold_m = hold_a; fbv_m = fbv_a; fb_m = fb_a;
    if (sel == 1) begin
      busy_m = busy_b; done_m = done_b; pulse_m = pulse_b;
      err_m = err_b; hold_m = hold_b; fbv_m = fbv_b; fb_m = fb_b;
    end else if (sel == 2) begin
      busy_m = busy_c; done_m = done_c; pulse_m = pulse_c;
      err_m = {14'd0, err_c}; hold_m = {14'd0, hold_c}; fbv_m = fbv_c; fb_m = fb_c;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_m), 0);
    chk({tag, "_done"}, 32'(done_m), 0);
    chk({tag, "_pulse"}, 32'(pulse_m), 0);
    chk({tag, "_err"}, 32'(err_m), 0);
    chk({tag, "_hold"}, 32'(hold_m), 0);
    chk({tag, "_fbv"}, 32'(fbv_m), 0);
    chk({tag, "_fb"}, 32'(fb_m), 0);
  endtask

  // Sequence-level reference: walk the sample array, classify each forward
  // distance modulo 16, and tally with a ceiling of 2^cw-1.
  task automatic model(input int load, input int w, input int cw,
                       output int e, output int h, output int fbv, output int fb);
    int prev, d, cap;
    cap = (1 << cw) - 1;
    prev = load; e = 0; h = 0; fbv = 0; fb = 0;
    for (int i = 0; i < w; i++) begin
      d = (seq[i] - prev + 16) % 16;
      exp_pulse[i] = 0;
      if (d == 0) begin
        if (h < cap) h++;
      end else if (d > 1) begin
        if (e < cap) e++;
        exp_pulse[i] = 1;
        if (fbv == 0) begin
          fbv = 1;
          fb = prev * 16 + seq[i];
        end
      end
      prev = seq[i];
    end
  endtask

  // Mostly +1 steps, some holds, occasional arbitrary jumps.
  task automatic gen(input int w, output int load);
    int prev, r;
    load = $urandom_range(0, 15);
    prev = load;
    for (int i = 0; i < w; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      prev = (prev + 1) % 16;
      else if (r < 82) prev = prev;
      else             prev = $urandom_range(0, 15);
      seq[i] = prev;
    end
  endtask

  task automatic run_and_check(input string tag, input int s, input int load, input int w,
                               input int exp_e, input int exp_h, input int exp_fbv,
                               input int exp_fb, input bit mid_start);
    @(negedge clk);
    sel = s;
    start_v = 1'b1;
    sample = 4'($urandom_range(0, 15));
    @(negedge clk);
    start_v = 1'b0;
    sample = 4'(load);
    chk({tag, "_load_busy"}, 32'(busy_m), 1);
    chk({tag, "_load_done"}, 32'(done_m), 0);
    chk({tag, "_load_err"}, 32'(err_m), 0);
    chk({tag, "_load_hold"}, 32'(hold_m), 0);
    chk({tag, "_load_fbv"}, 32'(fbv_m), 0);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      chk($sformatf("%s_pulse%0d", tag, i), 32'(pulse_m), (i == 0) ? 0 : exp_pulse[i-1]);
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy_m), 1);
      sample = 4'(seq[i]);
      start_v = mid_start && (i == 2);
    end
    @(negedge clk);
    start_v = 1'b0;
    chk({tag, "_pulse_last"}, 32'(pulse_m), exp_pulse[w-1]);
    chk({tag, "_done"}, 32'(done_m), 1);
    chk({tag, "_busy_done"}, 32'(busy_m), 0);
    chk({tag, "_err"}, 32'(err_m), exp_e);
    chk({tag, "_hold"}, 32'(hold_m), exp_h);
    chk({tag, "_fbv"}, 32'(fbv_m), exp_fbv);
    if (exp_fbv != 0) chk({tag, "_fb"}, 32'(fb_m), exp_fb);
    @(negedge clk);
    chk({tag, "_pulse_idle"}, 32'(pulse_m), 0);
    chk({tag, "_done_held"}, 32'(done_m), 1);
    chk({tag, "_err_frozen"}, 32'(err_m), exp_e);
  endtask

  initial begin
    int e, h, fbv, fb, load;

    // Reset with start asserted and random samples
    rst = 1'b1;
    start_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample = 4'($urandom_range(0, 15));
    end
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_all_zero($sformatf("rst%0d", s));
    end
    @(negedge clk);
    rst = 1'b0;
    start_v = 1'b0;
    sel = 0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy_m), 0);
    chk("idle_done", 32'(done_m), 0);

    // Clean wrap run on a: 14, 15, 0 .. 6
    for (int i = 0; i < 8; i++) seq[i] = (15 + i) % 16;
    model(14, 8, 16, e, h, fbv, fb);
    run_and_check("wrap", 0, 14, 8, 0, 0, 0, 0, 1'b0);

    // Corrupt jumps on b: 5 then 9, 10, 2, 3
    seq[0] = 9; seq[1] = 10; seq[2] = 2; seq[3] = 3;
    model(5, 4, 16, e, h, fbv, fb);
    run_and_check("jump", 1, 5, 4, 2, 0, 1, 32'h59, 1'b0);

    // Holds on b (restart from DONE must clear the earlier capture)
    seq[0] = 3; seq[1] = 3; seq[2] = 4; seq[3] = 5;
    model(3, 4, 16, e, h, fbv, fb);
    run_and_check("holds", 1, 3, 4, 0, 2, 0, 0, 1'b0);

    // Saturation on c: every compare corrupt, 2-bit counter sticks at 3
    for (int i = 0; i < 6; i++) seq[i] = (i % 2 == 0) ? 8 : 0;
    model(0, 6, 2, e, h, fbv, fb);
    run_and_check("sat", 2, 0, 6, 3, 0, 1, 32'h08, 1'b0);

    // Reset in the second RUN cycle on b
    @(negedge clk);
    sel = 1;
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    sample = 4'd5;
    @(negedge clk);
    sample = 4'd12;
    @(negedge clk);
    chk("mid_err_seen", 32'(pulse_m), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");
    @(negedge clk);
    chk("midrst_stay_idle", 32'(busy_m), 0);

    // Randomized runs on all three instances; a also gets a start during RUN
    for (int k = 0; k < 12; k++) begin
      int s, w, cw;
      s = k % 3;
      w = (s == 0) ? 8 : (s == 1) ? 4 : 6;
      cw = (s == 2) ? 2 : 16;
      gen(w, load);
      model(load, w, cw, e, h, fbv, fb);
      run_and_check($sformatf("rnd%0d", k), s, load, w, e, h, fbv, fb, (s == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
